// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM port among N_REQ requesters.
// Define ARB_LOCK_EN to compile in atomic lock sequences with a forced-release timeout.
module dpram_port_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req,
  input  logic [N_REQ-1:0]                 we,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]      wdata,
  input  logic [N_REQ-1:0]                 lock,
  output logic [N_REQ-1:0]                 gnt,
  output logic [N_REQ-1:0]                 rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             lock_err,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  // state    | meaning
  // S_IDLE   | round-robin scan from ptr over all requesters
  // S_LOCKED | only owner is eligible until its lock drops or times out
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] sel;
  logic [PW-1:0] sel_next;
  logic          any;

  // Second pass overrides the wrap-around pick with the first requester at or above ptr.
  always_comb begin
    sel = '0;
    any = 1'b0;
    if (state == S_LOCKED) begin
      sel = owner;
      for (int i = 0; i < N_REQ; i++)
        if (PW'(i) == owner) any = req[i];
    end else begin
      any = |req;
      for (int i = N_REQ - 1; i >= 0; i--)
        if (req[i]) sel = PW'(i);
      for (int i = N_REQ - 1; i >= 0; i--)
        if (req[i] && (PW'(i) >= ptr)) sel = PW'(i);
    end
  end

  assign sel_next = (sel == PW'(N_REQ - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    gnt       = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < N_REQ; i++)
      gnt[i] = !rst && any && (PW'(i) == sel);
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        mem_we    = we[i];
        mem_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign mem_en = |gnt;

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] cnt;
  logic          lock_err_q;
  logic          sel_lock;

  always_comb begin
    sel_lock = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      if (PW'(i) == sel) sel_lock = lock[i];
  end

  assign lock_err = lock_err_q;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign lock_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= '0;
      owner  <= '0;
      rdata  <= '0;
      rvalid <= '0;
`ifdef ARB_LOCK_EN
      cnt        <= '0;
      lock_err_q <= 1'b0;
`endif
    end else begin
      rvalid <= gnt & ~we;
      if (|(gnt & ~we)) rdata <= mem_rdata;
`ifdef ARB_LOCK_EN
      lock_err_q <= 1'b0;
      if (state == S_IDLE) begin
        if (any) begin
          ptr <= sel_next;
          if (sel_lock) begin
            state <= S_LOCKED;
            owner <= sel;
            cnt   <= CW'(1);
          end
        end
      end else if (!sel_lock) begin
        // in LOCKED sel is owner, so sel_next is owner+1
        state <= S_IDLE;
        ptr   <= sel_next;
        cnt   <= '0;
      end else if (cnt == CW'(MAX_LOCK)) begin
        state      <= S_IDLE;
        ptr        <= sel_next;
        cnt        <= '0;
        lock_err_q <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
`else
      if (any) ptr <= sel_next;
`endif
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural RAM on the shared port.
module tb_dpram_port_arbiter;
  logic         clk;
  logic         rst;
  logic [3:0]   req, we, lock;
  logic [31:0]  addr;
  logic [127:0] wdata;
  logic [3:0]   gnt, rvalid;
  logic [31:0]  rdata;
  logic         lock_err, mem_en, mem_we;
  logic [7:0]   mem_addr;
  logic [31:0]  mem_wdata, mem_rdata;
  logic         ram_init;
  logic [31:0]  ram [0:255];
  int checks = 0;
  int failures = 0;

  dpram_port_arbiter #(.N_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_LOCK(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .lock(lock),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .lock_err(lock_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [31:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*8 +: 8]   = a;
    wdata[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0; ram_init = 1'b1;
    tick();
    ram_init = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
      checks++; if (rvalid !== 4'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      tick();
    end
  endtask

  task automatic test_write_read();
    set_req(1, 1'b1, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL wr_gnt got=%b exp=0010", gnt); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL wr_en_we got=%b%b exp=11", mem_en, mem_we); end
    checks++; if (mem_addr !== 8'h10) begin failures++; $display("FAIL wr_addr got=%h exp=10", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_wdata got=%h exp=deadbeef", mem_wdata); end
    tick();
    set_req(1, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL rd_gnt got=%b exp=0010", gnt); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rd_we got=%b exp=0", mem_we); end
    checks++; if (rvalid !== 4'b0) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=0000", rvalid); end
    tick();
    req = '0;
    set_req(0, 1'b1, 8'h11, 32'h12345678);
    @(negedge clk);
    checks++; if (rvalid !== 4'b0010) begin failures++; $display("FAIL rd_rvalid got=%b exp=0010", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=deadbeef", rdata); end
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wrap_gnt got=%b exp=0001", gnt); end
    tick();
    req = '0;
    @(negedge clk);
    checks++; if (rvalid !== 4'b0) begin failures++; $display("FAIL rvalid_pulse got=%b exp=0000", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rdata_hold got=%h exp=deadbeef", rdata); end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(8'h40 + i), 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'(1 << exp_seq[k])) begin failures++; $display("FAIL rr_gnt step=%0d got=%b exp=%b", k, gnt, 4'(1 << exp_seq[k])); end
      checks++; if (mem_addr !== 8'(8'h40 + exp_seq[k])) begin failures++; $display("FAIL rr_addr step=%0d got=%h exp=%h", k, mem_addr, 8'(8'h40 + exp_seq[k])); end
      if (k > 0) begin
        checks++; if (rvalid !== 4'(1 << exp_seq[k-1])) begin failures++; $display("FAIL rr_rvalid step=%0d got=%b exp=%b", k, rvalid, 4'(1 << exp_seq[k-1])); end
      end
      tick();
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_requests();
    rst = 1'b1;
    set_req(2, 1'b1, 8'h30, 32'hAAAA0002);
    set_req(3, 1'b1, 8'h31, 32'hBBBB0003);
    repeat (2) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL rstreq_gnt got=%b exp=0000", gnt); end
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rstreq_mem_en got=%b exp=0", mem_en); end
      tick();
    end
    rst = 1'b0;
    checks++; if (ram[8'h30] !== 32'h0) begin failures++; $display("FAIL rstreq_ram_kept got=%h exp=0", ram[8'h30]); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rstreq_first got=%b exp=0100", gnt); end
    tick();
    req[2] = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL rstreq_second got=%b exp=1000", gnt); end
    tick();
    req = '0;
    @(negedge clk);
    checks++; if (ram[8'h30] !== 32'hAAAA0002) begin failures++; $display("FAIL rstreq_ram30 got=%h exp=aaaa0002", ram[8'h30]); end
    checks++; if (ram[8'h31] !== 32'hBBBB0003) begin failures++; $display("FAIL rstreq_ram31 got=%h exp=bbbb0003", ram[8'h31]); end
    tick();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock_rmw();
    rst = 1'b1; req = '0; lock = '0;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 8'h20, 32'd5);
    tick();
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, 8'h20, 32'h0);
    lock[0] = 1'b1;
    set_req(1, 1'b0, 8'h20, 32'h0);
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rmw_rd_gnt got=%b exp=0001", gnt); end
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL rmw_blocked got=%b exp=0000", gnt); end
    checks++; if (rvalid !== 4'b0001 || rdata !== 32'd5) begin failures++; $display("FAIL rmw_rdata got=%b/%h exp=0001/5", rvalid, rdata); end
    tick();
    set_req(0, 1'b1, 8'h20, 32'd6);
    lock[0] = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rmw_wr_gnt got=%b exp=0001", gnt); end
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL rmw_r1_gnt got=%b exp=0010", gnt); end
    tick();
    req = '0;
    @(negedge clk);
    checks++; if (rvalid !== 4'b0010 || rdata !== 32'd6) begin failures++; $display("FAIL rmw_r1_data got=%b/%h exp=0010/6", rvalid, rdata); end
    tick();
  endtask

  task automatic test_lock_timeout();
    rst = 1'b1; req = '0; lock = '0;
    tick();
    rst = 1'b0;
    set_req(2, 1'b0, 8'h50, 32'h0);
    lock[2] = 1'b1;
    set_req(3, 1'b0, 8'h51, 32'h0);
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL to_first got=%b exp=0100", gnt); end
    tick();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0100 || lock_err !== 1'b0) begin failures++; $display("FAIL to_held cyc=%0d got=%b/%b exp=0100/0", k, gnt, lock_err); end
      tick();
    end
    @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL to_next got=%b exp=1000", gnt); end
    checks++; if (lock_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", lock_err); end
    tick();
    req = '0; lock = '0;
    @(negedge clk);
    checks++; if (lock_err !== 1'b0) begin failures++; $display("FAIL to_err_pulse got=%b exp=0", lock_err); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_reset_requests();
`ifdef ARB_LOCK_EN
    test_lock_rmw();
    test_lock_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Round-robin arbiter that shares one port of the processor's dual-port RAM between `N_REQ` requesters (cores, DMA). It grants at most one access per cycle, drives the RAM port's en/we/addr/wdata fields, and returns registered read data to the granted requester. With the lock feature compiled in, it also supports atomic multi-access sequences such as read-modify-write. The other RAM port is outside this block's control; cross-port address collisions are the system's concern.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 8: RAM address width; must match the RAM instance.
- `DATA_WIDTH`, 32: RAM data width; must match the RAM instance.
- `MAX_LOCK`, 16: maximum cycles a lock may be held before forced release, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester access request; held with its fields until `gnt` is seen.
- `we`  in  N_REQ  per-requester write enable (1 = write, 0 = read).
- `addr`  in  N_REQ*ADDR_WIDTH  flattened addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `wdata`  in  N_REQ*DATA_WIDTH  flattened write data, sliced the same way.
- `lock`  in  N_REQ  per-requester lock request; used only with `ARB_LOCK_EN`.
- `gnt`  out  N_REQ  one-hot or zero; access performed in this cycle.
- `rvalid`  out  N_REQ  one-hot or zero; read data valid, one cycle after a read grant.
- `rdata`  out  DATA_WIDTH  registered read data, shared by all requesters.
- `lock_err`  out  1  one-cycle pulse on forced lock release.
- `mem_en`, `mem_we`  out  1  to the RAM port's `en`/`we`.
- `mem_addr`  out  ADDR_WIDTH  to the RAM port's `addr`.
- `mem_wdata`  out  DATA_WIDTH  to the RAM port's `wdata`.
- `mem_rdata`  in  DATA_WIDTH  from the RAM port's `rdata` (asynchronous read).

## Operation
- State: priority pointer `ptr` (0..N_REQ-1), FSM {IDLE, LOCKED}, `owner` index, lock cycle counter.
- IDLE: grant the first asserted `req` scanning from `ptr` upward with wrap-around. After a grant to index g, `ptr` ← (g+1) mod N_REQ. With no request, `ptr` holds.
- LOCKED: only `owner` is eligible; all other `gnt` = 0 regardless of `req`.
- On grant: `mem_en`=1; `mem_we`, `mem_addr` and `mem_wdata` come from the granted slice. With no grant: `mem_en`=0, `mem_we`=0, and `mem_addr`/`mem_wdata` = 0.
- Read grant: at the clock edge, `rdata` ← `mem_rdata` and `rvalid[g]` ← 1. Write grant: the RAM updates at the edge and no `rvalid` is raised.
- `rdata` holds its last value until the next read grant; `rvalid` is a single-cycle pulse.
- Requester protocol: `req` and its fields are held until the cycle in which `gnt` is high. The requester may drop `req` or present a new access in the following cycle. A `req` dropped before grant is legal and is simply not served.

## Timing
- Reset: `ptr`=0, FSM=IDLE, `owner`=0, counter=0, `rdata`=0, `rvalid`=0, `lock_err`=0.
- While `rst`=1: `gnt`=0 and `mem_en`=0 (combinational gating), so no RAM write happens.
- Reset asserted mid-lock returns to IDLE immediately, with no `lock_err`.
- Grant latency: combinational, 0 cycles from `req` when eligible.
- Write completes at the grant edge. Read data arrives 1 cycle after grant.
- Throughput: one access per cycle, with back-to-back grants allowed.
- Worst-case wait in IDLE: N_REQ-1 cycles, plus any lock hold time.

## Configuration
- `ARB_LOCK_EN` defined:
  - A grant to index g with `lock[g]`=1 moves the FSM to LOCKED with `owner`=g and counter=1.
  - In LOCKED, the counter increments every cycle.
  - Exit to IDLE at the first edge where `lock[owner]`=0, or where the counter reaches MAX_LOCK; the latter also pulses `lock_err` for 1 cycle.
  - On exit, `ptr` ← (owner+1) mod N_REQ.
  - The grant in a cycle where `lock[owner]` drops is still served.
- `ARB_LOCK_EN` undefined: `lock` is ignored, the FSM never leaves IDLE, and `lock_err` is tied to 0. Ports are unchanged.

## Test plan
- Reset, then idle 5 cycles: `gnt`=0, `mem_en`=0, `rvalid`=0, `rdata`=0 throughout.
- Requester 1 writes 0xDEADBEEF to 0x10, then reads 0x10: `gnt[1]` in both cycles, and `rvalid[1]`=1 with `rdata`=0xDEADBEEF one cycle after the read grant.
- All 4 requesters hold `req` from `ptr`=0: grant order 0,1,2,3,0 on consecutive cycles, one-hot `gnt` each cycle.
- Requesters 2 and 3 request while reset is asserted for 2 cycles: no `gnt`, no RAM change. After release, requester 2 is granted first.
- `ARB_LOCK_EN`: requester 0 locks for a read-modify-write on 0x20 (read 5, write 6) while requester 1 requests continuously. Requester 1 is granted only after `lock[0]` drops, and it reads 6.
- `ARB_LOCK_EN`, `MAX_LOCK`=16: requester 2 holds `lock` indefinitely. Forced release after 16 LOCKED cycles, a single `lock_err` pulse, and the next grant goes to requester 3 if it is requesting.
